// File: rtl/axis_bf_pkg.sv
// Shared constants and framer state encoding for the beamforming AXI-Stream chain.
package axis_bf_pkg;

   localparam int SSAMPLE_WIDTH = 16;
   localparam int SAMPLES = 8;
   localparam int SDATA_WIDTH = SSAMPLE_WIDTH * SAMPLES;
   localparam int FRAMER_FIFO_DEPTH = 4;
   localparam int FLEN_WIDTH = 16;
   localparam int LANE_WIDTH = $clog2(SAMPLES);
   localparam int WORD_WIDTH = 2 * SDATA_WIDTH + 1;

   typedef logic [1:0] framer_state_t;

   localparam framer_state_t ST_IDLE = 2'd0;
   localparam framer_state_t ST_FILL = 2'd1;
   localparam framer_state_t ST_DROP = 2'd2;
   localparam framer_state_t ST_TERM = 2'd3;

   // Index of the final word of a frame; a zero length behaves as a one-word frame.
   function automatic logic [FLEN_WIDTH-1:0] last_word_index(input logic [FLEN_WIDTH-1:0] len);
      logic [FLEN_WIDTH-1:0] idx;
      if (len == {FLEN_WIDTH{1'b0}}) begin
         idx = {FLEN_WIDTH{1'b0}};
      end else begin
         idx = len - FLEN_WIDTH'(1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/axis_word_fifo.sv
// Synchronous word FIFO with a registered head output; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module axis_word_fifo #(
   parameter int WIDTH = 257,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       din,
   input  logic                   pop,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    rd_ptr_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW:0]      count_r;
   logic [WIDTH-1:0] dout_r;

   logic             do_push_s;
   logic             do_pop_s;
   logic [AW:0]      remain_s;
   logic [AW:0]      next_count_s;
   logic [AW-1:0]    next_rd_s;
   logic [WIDTH-1:0] next_dout_s;

   // Accepted operations and the head word that will be visible after this edge.
   always_comb begin
      do_pop_s     = pop && (count_r != {(AW + 1){1'b0}});
      do_push_s    = push && ((count_r != FULL_COUNT) || do_pop_s);
      remain_s     = count_r - (AW + 1)'(do_pop_s);
      next_count_s = remain_s + (AW + 1)'(do_push_s);
      next_rd_s    = rd_ptr_r + AW'(do_pop_s);
      if (next_count_s == {(AW + 1){1'b0}}) begin
         next_dout_s = {WIDTH{1'b0}};
      end else if (remain_s == {(AW + 1){1'b0}}) begin
         next_dout_s = din;
      end else begin
         next_dout_s = mem_r[next_rd_s];
      end
   end

   // Storage array write port.
   always_ff @(posedge clock) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers, occupancy and registered head.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW + 1){1'b0}};
         dout_r   <= {WIDTH{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r <= next_rd_s;
         count_r  <= next_count_s;
         dout_r   <= next_dout_s;
      end
   end

   assign dout  = dout_r;
   assign full  = (count_r == FULL_COUNT);
   assign empty = (count_r == {(AW + 1){1'b0}});
   assign count = count_r;

endmodule

// File: rtl/axis_iq_framer.sv
// Packs a non-stallable ADC I/Q stream into lockstep real/imag 8-lane AXI-Stream
// words with frame tlast, terminating frames with a zero tlast word on overflow.
module axis_iq_framer
   import axis_bf_pkg::*;
#(
   parameter int FIFO_DEPTH = FRAMER_FIFO_DEPTH
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       enable,
   input  logic [FLEN_WIDTH-1:0]      frame_len,
   input  logic                       adc_valid,
   input  logic [SSAMPLE_WIDTH-1:0]   adc_i,
   input  logic [SSAMPLE_WIDTH-1:0]   adc_q,
   output logic [SDATA_WIDTH-1:0]     m_axis_real_tdata,
   output logic [SDATA_WIDTH/8-1:0]   m_axis_real_tkeep,
   output logic                       m_axis_real_tlast,
   output logic                       m_axis_real_tvalid,
   input  logic                       m_axis_real_tready,
   output logic [SDATA_WIDTH-1:0]     m_axis_imag_tdata,
   output logic [SDATA_WIDTH/8-1:0]   m_axis_imag_tkeep,
   output logic                       m_axis_imag_tlast,
   output logic                       m_axis_imag_tvalid,
   input  logic                       m_axis_imag_tready,
   output logic                       overflow,
   input  logic                       clear_overflow,
   output logic [31:0]                frames_sent
);

   localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(SAMPLES - 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   framer_state_t           state_r;
   framer_state_t           state_next_s;
   logic [LANE_WIDTH-1:0]   lane_r;
   logic [FLEN_WIDTH-1:0]   word_cnt_r;
   logic [FLEN_WIDTH-1:0]   last_idx_r;
   logic [SDATA_WIDTH-1:0]  pack_i_r;
   logic [SDATA_WIDTH-1:0]  pack_q_r;
   logic [SDATA_WIDTH-1:0]  word_i_r;
   logic [SDATA_WIDTH-1:0]  word_q_r;
   logic                    word_valid_r;
   logic                    word_last_r;
   logic                    overflow_r;
   logic [31:0]             frames_r;

   logic                    sample_s;
   logic                    word_done_s;
   logic                    frame_end_s;
   logic                    room_s;
   logic                    keep_s;
   logic                    drop_s;
   logic                    term_push_s;
   logic                    latch_s;
   logic                    pop_s;
   logic                    tvalid_s;
   logic                    fifo_push_s;
   logic [WORD_WIDTH-1:0]   fifo_din_s;
   logic [WORD_WIDTH-1:0]   fifo_dout_s;
   logic                    fifo_full_s;
   logic                    fifo_empty_s;
   logic [CW-1:0]           fifo_count_s;

   // Frame control: word completion, overflow decision and state sequencing.
   always_comb begin
      tvalid_s     = (fifo_count_s != {CW{1'b0}});
      pop_s        = !fifo_empty_s && m_axis_real_tready && m_axis_imag_tready;
      room_s       = !fifo_full_s || pop_s;
      sample_s     = adc_valid && ((state_r == ST_FILL) || (state_r == ST_DROP));
      word_done_s  = sample_s && (lane_r == LAST_LANE);
      frame_end_s  = word_done_s && (word_cnt_r == last_idx_r);
      keep_s       = word_done_s && (state_r == ST_FILL) && room_s;
      drop_s       = word_done_s && (state_r == ST_FILL) && !room_s;
      term_push_s  = (state_r == ST_TERM) && room_s;
      state_next_s = state_r;
      latch_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_next_s = ST_FILL;
               latch_s      = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (drop_s) begin
               state_next_s = frame_end_s ? ST_TERM : ST_DROP;
            end else if (frame_end_s) begin
               state_next_s = enable ? ST_FILL : ST_IDLE;
               latch_s      = enable;
            end else begin
               state_next_s = ST_FILL;
            end
         end
         ST_DROP: begin
            if (frame_end_s) begin
               state_next_s = ST_TERM;
            end else begin
               state_next_s = ST_DROP;
            end
         end
         ST_TERM: begin
            if (term_push_s) begin
               state_next_s = enable ? ST_FILL : ST_IDLE;
               latch_s      = enable;
            end else begin
               state_next_s = ST_TERM;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      fifo_push_s = word_valid_r || term_push_s;
      // A completed word and a terminating word are never pending together.
      if (word_valid_r) begin
         fifo_din_s = {word_last_r, word_q_r, word_i_r};
      end else begin
         fifo_din_s = {1'b1, {(2 * SDATA_WIDTH){1'b0}}};
      end
   end

   // State, lane/word counters and latched frame length.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         lane_r     <= {LANE_WIDTH{1'b0}};
         word_cnt_r <= {FLEN_WIDTH{1'b0}};
         last_idx_r <= {FLEN_WIDTH{1'b0}};
      end else begin
         state_r <= state_next_s;
         if (latch_s) begin
            last_idx_r <= last_word_index(frame_len);
         end
         if (sample_s) begin
            lane_r <= lane_r + LANE_WIDTH'(1);
         end
         if (word_done_s) begin
            word_cnt_r <= frame_end_s ? {FLEN_WIDTH{1'b0}} : word_cnt_r + FLEN_WIDTH'(1);
         end
      end
   end

   // Lane packing and the completed-word register feeding the FIFO.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         pack_i_r     <= {SDATA_WIDTH{1'b0}};
         pack_q_r     <= {SDATA_WIDTH{1'b0}};
         word_i_r     <= {SDATA_WIDTH{1'b0}};
         word_q_r     <= {SDATA_WIDTH{1'b0}};
         word_valid_r <= 1'b0;
         word_last_r  <= 1'b0;
      end else begin
         if (sample_s && (state_r == ST_FILL)) begin
            pack_i_r[int'(lane_r) * SSAMPLE_WIDTH +: SSAMPLE_WIDTH] <= adc_i;
            pack_q_r[int'(lane_r) * SSAMPLE_WIDTH +: SSAMPLE_WIDTH] <= adc_q;
         end
         word_valid_r <= keep_s;
         if (keep_s) begin
            word_i_r    <= {adc_i, pack_i_r[SDATA_WIDTH-SSAMPLE_WIDTH-1:0]};
            word_q_r    <= {adc_q, pack_q_r[SDATA_WIDTH-SSAMPLE_WIDTH-1:0]};
            word_last_r <= frame_end_s;
         end
      end
   end

   // Sticky overflow (set beats clear) and handshaked-frame counter.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         overflow_r <= 1'b0;
         frames_r   <= 32'd0;
      end else begin
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clear_overflow) begin
            overflow_r <= 1'b0;
         end
         if (pop_s && fifo_dout_s[WORD_WIDTH-1]) begin
            frames_r <= frames_r + 32'd1;
         end
      end
   end

   axis_word_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock  (clock),
      .resetn (resetn),
      .push   (fifo_push_s),
      .din    (fifo_din_s),
      .pop    (pop_s),
      .dout   (fifo_dout_s),
      .full   (fifo_full_s),
      .empty  (fifo_empty_s),
      .count  (fifo_count_s)
   );

   assign m_axis_real_tdata  = fifo_dout_s[SDATA_WIDTH-1:0];
   assign m_axis_imag_tdata  = fifo_dout_s[2*SDATA_WIDTH-1:SDATA_WIDTH];
   assign m_axis_real_tlast  = fifo_dout_s[WORD_WIDTH-1];
   assign m_axis_imag_tlast  = fifo_dout_s[WORD_WIDTH-1];
   assign m_axis_real_tvalid = tvalid_s;
   assign m_axis_imag_tvalid = tvalid_s;
   assign m_axis_real_tkeep  = {(SDATA_WIDTH/8){tvalid_s}};
   assign m_axis_imag_tkeep  = {(SDATA_WIDTH/8){tvalid_s}};
   assign overflow           = overflow_r;
   assign frames_sent        = frames_r;

endmodule

// File: tb/tb_axis_iq_framer.sv
// Directed bench for axis_iq_framer: expected words are queued as samples are
// driven and compared against every output handshake.
module tb_axis_iq_framer;
   import axis_bf_pkg::*;

   typedef struct {
      logic [127:0] i;
      logic [127:0] q;
      logic         last;
   } exp_t;

   logic          clock;
   logic          resetn;
   logic          enable;
   logic [15:0]   frame_len;
   logic          adc_valid;
   logic [15:0]   adc_i;
   logic [15:0]   adc_q;
   logic [127:0]  m_axis_real_tdata;
   logic [15:0]   m_axis_real_tkeep;
   logic          m_axis_real_tlast;
   logic          m_axis_real_tvalid;
   logic          m_axis_real_tready;
   logic [127:0]  m_axis_imag_tdata;
   logic [15:0]   m_axis_imag_tkeep;
   logic          m_axis_imag_tlast;
   logic          m_axis_imag_tvalid;
   logic          m_axis_imag_tready;
   logic          overflow;
   logic          clear_overflow;
   logic [31:0]   frames_sent;

   int   errors;
   int   checks;
   int   exp_frames;
   logic rand_rdy;
   exp_t sb[$];

   axis_iq_framer dut (
      .clock              (clock),
      .resetn             (resetn),
      .enable             (enable),
      .frame_len          (frame_len),
      .adc_valid          (adc_valid),
      .adc_i              (adc_i),
      .adc_q              (adc_q),
      .m_axis_real_tdata  (m_axis_real_tdata),
      .m_axis_real_tkeep  (m_axis_real_tkeep),
      .m_axis_real_tlast  (m_axis_real_tlast),
      .m_axis_real_tvalid (m_axis_real_tvalid),
      .m_axis_real_tready (m_axis_real_tready),
      .m_axis_imag_tdata  (m_axis_imag_tdata),
      .m_axis_imag_tkeep  (m_axis_imag_tkeep),
      .m_axis_imag_tlast  (m_axis_imag_tlast),
      .m_axis_imag_tvalid (m_axis_imag_tvalid),
      .m_axis_imag_tready (m_axis_imag_tready),
      .overflow           (overflow),
      .clear_overflow     (clear_overflow),
      .frames_sent        (frames_sent)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_rdy) begin
         m_axis_real_tready = ($urandom_range(0, 3) != 0);
         m_axis_imag_tready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic [15:0] i, input logic [15:0] q);
      adc_valid = 1'b1;
      adc_i     = i;
      adc_q     = q;
      tick();
      adc_valid = 1'b0;
   endtask

   task automatic send_word(input int base, input logic last, input logic keep);
      exp_t        e;
      logic [15:0] v;
      for (int k = 0; k < 8; k++) begin
         v = 16'(base + k);
         e.i[k*16 +: 16] = v;
         e.q[k*16 +: 16] = 16'd0 - v;
      end
      e.last = last;
      if (keep) sb.push_back(e);
      for (int k = 0; k < 8; k++) begin
         v = 16'(base + k);
         sample(v, 16'd0 - v);
      end
   endtask

   // Starts from IDLE; enable is released during the final word so the frame ends in IDLE.
   task automatic send_frame(input int n, input int base);
      frame_len = 16'(n);
      enable    = 1'b1;
      tick();
      for (int w = 0; w < n; w++) begin
         if (w == n - 1) enable = 1'b0;
         send_word(base + 8 * w, (w == n - 1), 1'b1);
      end
      exp_frames++;
   endtask

   task automatic drain(input string tag);
      for (int c = 0; c < 400 && sb.size() != 0; c++) tick();
      for (int c = 0; c < 4; c++) tick();
      check(tag, 128'(sb.size()), 128'd0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exp_frames = 0;
      rand_rdy = 1'b0;
      resetn = 1'b0;
      enable = 1'b0;
      frame_len = 16'd0;
      adc_valid = 1'b0;
      adc_i = 16'd0;
      adc_q = 16'd0;
      clear_overflow = 1'b0;
      m_axis_real_tready = 1'b1;
      m_axis_imag_tready = 1'b1;

      fork
         begin : monitor
            exp_t         e;
            logic         hold;
            logic [127:0] prev_i;
            logic [127:0] prev_q;
            logic         prev_l;
            hold = 1'b0;
            prev_i = 128'd0;
            prev_q = 128'd0;
            prev_l = 1'b0;
            forever begin
               @(negedge clock);
               checks++;
               assert (m_axis_real_tvalid === m_axis_imag_tvalid) else begin
                  errors++;
                  $error("FAIL tvalid_lockstep real=%0b imag=%0b", m_axis_real_tvalid, m_axis_imag_tvalid);
               end
               checks++;
               assert ((m_axis_real_tkeep === {16{m_axis_real_tvalid}}) && (m_axis_imag_tkeep === {16{m_axis_imag_tvalid}})) else begin
                  errors++;
                  $error("FAIL tkeep observed=%0h/%0h expected=%0h", m_axis_real_tkeep, m_axis_imag_tkeep, {16{m_axis_real_tvalid}});
               end
               if (hold) begin
                  checks++;
                  assert ((m_axis_real_tvalid === 1'b1) && (m_axis_real_tdata === prev_i) &&
                          (m_axis_imag_tdata === prev_q) && (m_axis_real_tlast === prev_l)) else begin
                     errors++;
                     $error("FAIL stall_hold observed=%0h expected=%0h", m_axis_real_tdata, prev_i);
                  end
               end
               if (m_axis_real_tvalid && m_axis_real_tready && m_axis_imag_tready) begin
                  checks++;
                  assert (sb.size() != 0) else begin
                     errors++;
                     $error("FAIL unexpected_word observed=%0h expected=none", m_axis_real_tdata);
                  end
                  if (sb.size() != 0) begin
                     e = sb.pop_front();
                     checks++;
                     assert (m_axis_real_tdata === e.i) else begin
                        errors++;
                        $error("FAIL real_tdata observed=%0h expected=%0h", m_axis_real_tdata, e.i);
                     end
                     checks++;
                     assert (m_axis_imag_tdata === e.q) else begin
                        errors++;
                        $error("FAIL imag_tdata observed=%0h expected=%0h", m_axis_imag_tdata, e.q);
                     end
                     checks++;
                     assert ((m_axis_real_tlast === e.last) && (m_axis_imag_tlast === e.last)) else begin
                        errors++;
                        $error("FAIL tlast observed=%0b/%0b expected=%0b", m_axis_real_tlast, m_axis_imag_tlast, e.last);
                     end
                  end
               end
               hold   = resetn && m_axis_real_tvalid && !(m_axis_real_tready && m_axis_imag_tready);
               prev_i = m_axis_real_tdata;
               prev_q = m_axis_imag_tdata;
               prev_l = m_axis_real_tlast;
            end
         end
      join_none

      // Reset state
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      check("rst_tvalid", 128'(m_axis_real_tvalid), 128'd0);
      check("rst_tdata", m_axis_real_tdata | m_axis_imag_tdata, 128'd0);
      check("rst_tlast", 128'(m_axis_real_tlast), 128'd0);
      check("rst_overflow", 128'(overflow), 128'd0);
      check("rst_frames", 128'(frames_sent), 128'd0);

      // 1: two-word frame, first tvalid two cycles after the eighth sample
      frame_len = 16'd2;
      enable = 1'b1;
      tick();
      send_word(0, 1'b0, 1'b1);
      check("t1_no_early_valid", 128'(m_axis_real_tvalid), 128'd0);
      tick();
      check("t1_valid_n2", 128'(m_axis_real_tvalid), 128'd1);
      check("t1_lane0", 128'(m_axis_real_tdata[15:0]), 128'd0);
      enable = 1'b0;
      send_word(8, 1'b1, 1'b1);
      exp_frames++;
      drain("t1_drain");
      check("t1_frames", 128'(frames_sent), 128'd1);

      // 2: random backpressure across three 4-word frames
      rand_rdy = 1'b1;
      for (int f = 0; f < 3; f++) send_frame(4, 100 + 64 * f);
      drain("t2_drain");
      rand_rdy = 1'b0;
      m_axis_real_tready = 1'b1;
      m_axis_imag_tready = 1'b1;
      check("t2_frames", 128'(frames_sent), 128'(exp_frames));

      // 3: only one channel ready -> nothing pops
      m_axis_imag_tready = 1'b0;
      send_frame(1, 500);
      repeat (6) tick();
      check("t3_real_valid", 128'(m_axis_real_tvalid), 128'd1);
      check("t3_imag_valid", 128'(m_axis_imag_tvalid), 128'd1);
      check("t3_no_pop", 128'(sb.size()), 128'd1);
      m_axis_imag_tready = 1'b1;
      drain("t3_drain");

      // 4: overflow with both readies low on an 8-word frame
      m_axis_real_tready = 1'b0;
      m_axis_imag_tready = 1'b0;
      frame_len = 16'd8;
      enable = 1'b1;
      tick();
      for (int w = 0; w < 8; w++) begin
         if (w == 7) enable = 1'b0;
         send_word(2000 + 8 * w, 1'b0, (w < 4));
         if (w == 3) check("t4_no_overflow_yet", 128'(overflow), 128'd0);
         if (w == 4) check("t4_overflow_set", 128'(overflow), 128'd1);
      end
      begin
         exp_t z;
         z.i = 128'd0;
         z.q = 128'd0;
         z.last = 1'b1;
         sb.push_back(z);
      end
      exp_frames++;
      repeat (3) tick();
      check("t4_frames_held", 128'(frames_sent), 128'(exp_frames - 1));
      m_axis_real_tready = 1'b1;
      m_axis_imag_tready = 1'b1;
      drain("t4_drain");
      check("t4_frames", 128'(frames_sent), 128'(exp_frames));
      check("t4_overflow_sticky", 128'(overflow), 128'd1);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      check("t4_overflow_clear", 128'(overflow), 128'd0);
      send_frame(2, 3000);
      drain("t4_next_drain");
      check("t4_next_frames", 128'(frames_sent), 128'(exp_frames));

      // 5: enable released mid-frame, then samples in IDLE are ignored
      send_frame(3, 4000);
      for (int k = 0; k < 16; k++) sample(16'(7000 + k), 16'd1);
      drain("t5_drain");
      check("t5_idle_no_word", 128'(m_axis_real_tvalid), 128'd0);
      check("t5_frames", 128'(frames_sent), 128'(exp_frames));

      // 6: reset mid-word with a queued word
      m_axis_real_tready = 1'b0;
      m_axis_imag_tready = 1'b0;
      frame_len = 16'd2;
      enable = 1'b1;
      tick();
      send_word(5000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) sample(16'(5100 + k), 16'd2);
      enable = 1'b0;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      exp_frames = 0;
      check("t6_tvalid", 128'(m_axis_real_tvalid | m_axis_imag_tvalid), 128'd0);
      check("t6_tdata", m_axis_real_tdata | m_axis_imag_tdata, 128'd0);
      check("t6_tkeep", 128'(m_axis_real_tkeep | m_axis_imag_tkeep), 128'd0);
      check("t6_tlast", 128'(m_axis_real_tlast | m_axis_imag_tlast), 128'd0);
      check("t6_frames", 128'(frames_sent), 128'd0);
      m_axis_real_tready = 1'b1;
      m_axis_imag_tready = 1'b1;
      send_frame(1, 6000);
      drain("t6_drain");
      check("t6_frames_after", 128'(frames_sent), 128'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
